// File: rtl/s1488_n55_bist.sv
// Built-in self-test driver for the s1488 n55 cone: LFSR pattern source,
// serial MISR response compactor and golden-signature compare.
//
// state | meaning
// IDLE  | waiting for start; pattern, signature, count and pass hold
// RUN   | one LFSR pattern presented per cycle, responses compacted
// DRAIN | RESP_LAT cycles absorbing responses still in flight
// DONE  | one-cycle done pulse; pass captured from signature == gold
module s1488_n55_bist #(
    parameter int          NPAT      = 256,
    parameter logic [13:0] SEED      = 14'h0001,
    parameter logic [15:0] MISR_SEED = 16'h0000,
    parameter int          RESP_LAT  = 0
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] gold,
    input  logic        resp_in,
    output logic [13:0] pat_out,
    output logic        pat_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] pat_cnt
);

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [13:0] SEED_EFF = (SEED == 14'h0000) ? 14'h0001 : SEED;
    localparam logic [15:0] LAST_CNT = 16'(NPAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        run_last;
    logic        resp_ok;
    logic        drain_end;
    logic [13:0] lfsr_next;
    logic [15:0] misr_next;

    assign run_last  = (state == RUN) && (pat_cnt == LAST_CNT);
    assign lfsr_next = {pat_out[12:0], pat_out[13] ^ pat_out[4] ^ pat_out[2] ^ pat_out[0]};
    assign misr_next = {signature[14:0],
                        signature[15] ^ signature[13] ^ signature[12] ^ signature[10] ^ resp_in};

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pat_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                pat_valid = 1'b1;
                busy      = 1'b1;
                if (run_last) begin
                    state_next = (RESP_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The final pattern is not stepped past, so pat_out holds it through DRAIN and IDLE.
    always_ff @(posedge CK) begin
        if (RST) begin
            pat_out   <= '0;
            signature <= '0;
            pat_cnt   <= '0;
            pass      <= 1'b0;
        end else if ((state == IDLE) && start) begin
            pat_out   <= SEED_EFF;
            signature <= MISR_SEED;
            pat_cnt   <= '0;
            pass      <= 1'b0;
        end else begin
            if (state == RUN) begin
                pat_cnt <= pat_cnt + 16'd1;
                if (!run_last) begin
                    pat_out <= lfsr_next;
                end
            end
            if (resp_ok) begin
                signature <= misr_next;
            end
            if (state == DONE) begin
                pass <= (signature == gold);
            end
        end
    end

    generate
        if (RESP_LAT == 0) begin : g_direct
            assign resp_ok   = (state == RUN);
            assign drain_end = 1'b1;
        end else begin : g_delayed
            logic [RESP_LAT-1:0] vld;
            logic [1:0]          drain_cnt;

            // Each RUN cycle launches a response that lands RESP_LAT edges later.
            always_ff @(posedge CK) begin
                if (RST) begin
                    vld       <= '0;
                    drain_cnt <= '0;
                end else begin
                    vld <= RESP_LAT'({vld, (state == RUN)});
                    if (run_last) begin
                        drain_cnt <= 2'(RESP_LAT - 1);
                    end else if ((state == DRAIN) && (drain_cnt != 2'd0)) begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
            end

            assign resp_ok   = vld[RESP_LAT-1];
            assign drain_end = (drain_cnt == 2'd0);
        end
    endgenerate

endmodule

// File: tb/tb_s1488_n55_bist.sv
// Bench for s1488_n55_bist: two instances (combinational and 2-cycle cone) checked
// every cycle against a run-timeline model, plus literal anchor values.
module tb_s1488_n55_bist;

    localparam int NP_A  = 5;
    localparam int LAT_A = 0;
    localparam int NP_B  = 3;
    localparam int LAT_B = 2;

    logic        CK = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] gold_a, gold_b;
    logic        resp_a, resp_b;
    int          mode_a, mode_b;

    logic [13:0] pat_a, pat_b;
    logic        pv_a, pv_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] sig_a, sig_b, cnt_a, cnt_b;

    logic        pv_b_d1 = 1'b0;
    logic        pv_b_d2 = 1'b0;

    always #5 CK = ~CK;

    s1488_n55_bist #(.NPAT(NP_A), .RESP_LAT(LAT_A)) u_a (
        .CK(CK), .RST(RST), .start(start), .gold(gold_a), .resp_in(resp_a),
        .pat_out(pat_a), .pat_valid(pv_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a)
    );

    s1488_n55_bist #(.NPAT(NP_B), .RESP_LAT(LAT_B)) u_b (
        .CK(CK), .RST(RST), .start(start), .gold(gold_b), .resp_in(resp_b),
        .pat_out(pat_b), .pat_valid(pv_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b)
    );

    // Cone stand-ins: constants, a combinational function of the pattern,
    // or pat_valid delayed two cycles for the registered cone.
    assign resp_a = (mode_a == 0) ? 1'b0 : (mode_a == 1) ? 1'b1 : (pat_a[1] ^ pat_a[5] ^ pat_a[8]);
    assign resp_b = (mode_b == 0) ? 1'b0 : (mode_b == 1) ? 1'b1 : pv_b_d2;

    always @(posedge CK) begin
        pv_b_d1 <= pv_b;
        pv_b_d2 <= pv_b_d1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: per instance, cycle index t within a run.
    int          np_k  [2] = '{NP_A, NP_B};
    int          lat_k [2] = '{LAT_A, LAT_B};
    bit          running [2];
    int          t     [2];
    logic [13:0] mpat  [2];
    logic [15:0] msig  [2];
    logic [15:0] mcnt  [2];
    logic        mpass [2];
    int          st_cyc   [2];
    int          done_cyc [2];
    int          cyc = 0;

    logic [13:0] plog [8];
    int          log_n  = 0;
    int          drain_n = 0;
    int          done_n  = 0;

    function automatic logic [13:0] lfsr_step(input logic [13:0] p);
        return {p[12:0], p[13] ^ p[4] ^ p[2] ^ p[0]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ r};
    endfunction

    task automatic model_step(input int k, input logic r, input logic [15:0] g);
        if (RST) begin
            running[k] = 1'b0;
            t[k]       = 0;
            mpat[k]    = '0;
            msig[k]    = '0;
            mcnt[k]    = '0;
            mpass[k]   = 1'b0;
        end else if (!running[k]) begin
            if (start) begin
                running[k] = 1'b1;
                t[k]       = 0;
                mpat[k]    = 14'h0001;
                msig[k]    = 16'h0000;
                mcnt[k]    = '0;
                mpass[k]   = 1'b0;
                st_cyc[k]  = cyc;
            end
        end else begin
            if (t[k] >= lat_k[k] && t[k] < np_k[k] + lat_k[k])
                msig[k] = misr_step(msig[k], r);
            if (t[k] < np_k[k]) begin
                mcnt[k] = 16'(t[k] + 1);
                if (t[k] + 1 < np_k[k])
                    mpat[k] = lfsr_step(mpat[k]);
            end
            if (t[k] == np_k[k] + lat_k[k]) begin
                mpass[k]   = (msig[k] == g);
                running[k] = 1'b0;
            end
            t[k]++;
        end
    endtask

    always @(posedge CK) begin
        cyc++;
        model_step(0, resp_a, gold_a);
        model_step(1, resp_b, gold_b);
    end

    task automatic cmp(input int k, input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, got, exp, $time);
        end
    endtask

    task automatic check(input int k, input logic [13:0] p, input logic v, input logic b,
                         input logic d, input logic ps, input logic [15:0] s, input logic [15:0] c);
        logic ev, eb, ed;
        ev = running[k] && (t[k] < np_k[k]);
        eb = running[k] && (t[k] < np_k[k] + lat_k[k]);
        ed = running[k] && (t[k] == np_k[k] + lat_k[k]);
        cmp(k, "pat_out",   16'(p),  16'(mpat[k]));
        cmp(k, "pat_valid", 16'(v),  16'(ev));
        cmp(k, "busy",      16'(b),  16'(eb));
        cmp(k, "done",      16'(d),  16'(ed));
        cmp(k, "pass",      16'(ps), 16'(mpass[k]));
        cmp(k, "signature", s,       msig[k]);
        cmp(k, "pat_cnt",   c,       mcnt[k]);
    endtask

    always @(negedge CK) begin
        if (chk_en) begin
            check(0, pat_a, pv_a, busy_a, done_a, pass_a, sig_a, cnt_a);
            check(1, pat_b, pv_b, busy_b, done_b, pass_b, sig_b, cnt_b);
            if (done_a) begin done_cyc[0] = cyc; done_n++; end
            if (done_b) begin done_cyc[1] = cyc; done_n++; end
            if (pv_a && log_n < 8) begin plog[log_n] = pat_a; log_n++; end
            if (busy_b && !pv_b) drain_n++;
        end
    end

    task automatic pulse_start();
        done_cyc[0] = -1;
        done_cyc[1] = -1;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    task automatic wait_runs(input int budget, input string nm);
        int n = 0;
        while ((done_cyc[0] < 0 || done_cyc[1] < 0) && n < budget) begin
            @(posedge CK);
            n++;
        end
        n_chk++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", nm, budget);
        end
        @(negedge CK);
        @(negedge CK);
    endtask

    logic [13:0] exp_pat [5] = '{14'h0001, 14'h0003, 14'h0007, 14'h000E, 14'h001D};

    initial begin
        RST = 1'b1; start = 1'b0; gold_a = '0; gold_b = '0; mode_a = 0; mode_b = 0;
        done_cyc[0] = -1; done_cyc[1] = -1;
        @(negedge CK);
        chk_en = 1'b1;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        @(negedge CK);
        RST = 1'b0;
        repeat (3) @(negedge CK);
        cmp(0, "idle_pat_out", 16'(pat_a), 16'h0000);
        cmp(0, "idle_busy", 16'(busy_a), 16'h0000);
        cmp(1, "idle_signature", sig_b, 16'h0000);

        // Run 1: pattern-dependent response on A, delayed pat_valid on B.
        mode_a = 2; mode_b = 2; gold_a = 16'h0000; gold_b = 16'h0007;
        log_n = 0; drain_n = 0;
        pulse_start();
        wait_runs(40, "run1");
        cmp(0, "run1_latency", 16'(done_cyc[0] - st_cyc[0]), 16'd5);
        cmp(1, "run1_latency", 16'(done_cyc[1] - st_cyc[1]), 16'd5);
        cmp(0, "run1_pat_cnt", cnt_a, 16'd5);
        cmp(0, "run1_pat_count_logged", 16'(log_n), 16'd5);
        for (int i = 0; i < 5; i++) cmp(0, "run1_pat_seq", 16'(plog[i]), 16'(exp_pat[i]));
        cmp(1, "run1_drain_cycles", 16'(drain_n), 16'd2);
        cmp(1, "run1_signature", sig_b, 16'h0007);
        cmp(1, "run1_pass", 16'(pass_b), 16'h0001);

        // Run 2: responses tied 0 on A, tied 1 on B.
        mode_a = 0; mode_b = 1; gold_a = 16'h0000; gold_b = 16'h0001;
        pulse_start();
        wait_runs(40, "run2");
        cmp(0, "run2_signature", sig_a, 16'h0000);
        cmp(0, "run2_pass", 16'(pass_a), 16'h0001);
        cmp(1, "run2_signature", sig_b, 16'h0007);
        cmp(1, "run2_pass", 16'(pass_b), 16'h0000);

        // Run 3: wrong gold on A; start pulses mid-run and in DONE are ignored.
        mode_a = 0; mode_b = 2; gold_a = 16'h0001; gold_b = 16'h0007;
        pulse_start();
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (3) @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        wait_runs(40, "run3");
        cmp(0, "run3_latency", 16'(done_cyc[0] - st_cyc[0]), 16'd5);
        cmp(0, "run3_pat_cnt", cnt_a, 16'd5);
        cmp(0, "run3_pass", 16'(pass_a), 16'h0000);
        cmp(0, "run3_no_restart", 16'(busy_a), 16'h0000);
        cmp(1, "run3_pass", 16'(pass_b), 16'h0001);

        // Run 4: reset mid-run at pat_cnt == 2.
        mode_a = 2;
        pulse_start();
        begin
            int n = 0;
            while (cnt_a != 16'd2 && n < 20) begin
                @(negedge CK);
                n++;
            end
            cmp(0, "run4_reach_cnt2", cnt_a, 16'd2);
        end
        done_n = 0;
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        repeat (10) @(negedge CK);
        cmp(0, "run4_no_done", 16'(done_n), 16'd0);
        cmp(0, "run4_pat_out", 16'(pat_a), 16'h0000);
        cmp(0, "run4_pat_cnt", cnt_a, 16'h0000);
        cmp(1, "run4_busy", 16'(busy_b), 16'h0000);

        // Run 5: recovery after reset, responses tied 1 on A.
        mode_a = 1; mode_b = 0; gold_a = 16'h001F; gold_b = 16'h0000;
        pulse_start();
        wait_runs(40, "run5");
        cmp(0, "run5_signature", sig_a, 16'h001F);
        cmp(0, "run5_pass", 16'(pass_a), 16'h0001);
        cmp(1, "run5_signature", sig_b, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
